demux_stream_nch: RTL and testbench

DEMUX_STREAM_NCH -- requirements
Module: demux_stream_nch

---
 rtl/demux_stream_nch.sv | 95 +++++++++
 tb/tb_demux_stream_nch.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_stream_nch.sv
// One-input, NUM_CH-output stream demultiplexer with one output register per channel.
// Optional per-channel delivered-beat counters are built when DEMUX_CNT_EN is defined.
module demux_stream_nch #(
  parameter int BUS_WIDTH = 8,
  parameter int NUM_CH    = 4,
  parameter int SEL_WIDTH = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [BUS_WIDTH-1:0]        in_data,
  input  logic [SEL_WIDTH-1:0]        in_sel,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [NUM_CH*BUS_WIDTH-1:0] out_data,
  output logic [NUM_CH-1:0]           out_valid,
  input  logic [NUM_CH-1:0]           out_ready,
  output logic                        sel_err
`ifdef DEMUX_CNT_EN
  ,
  output logic [NUM_CH*16-1:0]        beat_cnt
`endif
);

  logic [NUM_CH-1:0]           valid_q, valid_d;
  logic [NUM_CH*BUS_WIDTH-1:0] data_q, data_d;
  logic                        sel_err_q, sel_err_d;
  logic [NUM_CH-1:0]           load;
  logic [NUM_CH-1:0]           pop;
  logic                        sel_hit;

  // An out-of-range select never matches a channel, so in_ready stays 1 and the beat is dropped.
  always_comb begin
    in_ready = 1'b1;
    sel_hit  = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (in_sel == SEL_WIDTH'(k)) begin
        sel_hit  = 1'b1;
        in_ready = ~valid_q[k] | out_ready[k];
      end
    end
  end

  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    load      = '0;
    pop       = valid_q & out_ready;
    sel_err_d = sel_err_q | (in_valid & ~sel_hit);
    for (int k = 0; k < NUM_CH; k++) begin
      load[k]    = in_valid & in_ready & (in_sel == SEL_WIDTH'(k));
      valid_d[k] = load[k] | (valid_q[k] & ~out_ready[k]);
      if (load[k]) begin
        data_d[k*BUS_WIDTH +: BUS_WIDTH] = in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      data_q    <= '0;
      sel_err_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      data_q    <= data_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign sel_err   = sel_err_q;

`ifdef DEMUX_CNT_EN
  logic [NUM_CH*16-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < NUM_CH; k++) begin
      cnt_d[k*16 +: 16] = cnt_q[k*16 +: 16] + 16'(pop[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign beat_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_demux_stream_nch.sv
// Self-checking bench for demux_stream_nch: directed scenarios plus a randomized run
// against a queue-based channel model; a second 3-channel instance covers bad selects.
module tb_demux_stream_nch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          checks = 0;
  int          errors = 0;

  // 4-channel instance
  logic [7:0]  in_data = '0;
  logic [1:0]  in_sel = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = '0;
  logic        sel_err;

  // 3-channel instance
  logic [7:0]  in_data3 = '0;
  logic [1:0]  in_sel3 = '0;
  logic        in_valid3 = 1'b0;
  logic        in_ready3;
  logic [23:0] out_data3;
  logic [2:0]  out_valid3;
  logic [2:0]  out_ready3 = '0;
  logic        sel_err3;

`ifdef DEMUX_CNT_EN
  logic [63:0] beat_cnt;
  logic [47:0] beat_cnt3;
`endif

  always #5 clk = ~clk;

  demux_stream_nch #(.BUS_WIDTH(8), .NUM_CH(4), .SEL_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .sel_err(sel_err)
`ifdef DEMUX_CNT_EN
    , .beat_cnt(beat_cnt)
`endif
  );

  demux_stream_nch #(.BUS_WIDTH(8), .NUM_CH(3), .SEL_WIDTH(2)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data3), .in_sel(in_sel3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3), .sel_err(sel_err3)
`ifdef DEMUX_CNT_EN
    , .beat_cnt(beat_cnt3)
`endif
  );

  typedef logic [7:0] byte_q_t[$];
  byte_q_t mq[4];

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0; in_valid3 = 1'b0;
    out_ready = '0; out_ready3 = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0; in_sel = 2'd0; out_ready = '0;
    #1;
    checks++;
    if (out_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid got %b want 0000", out_valid); end
    checks++;
    if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 00000000", out_data); end
    checks++;
    if (sel_err !== 1'b0) begin errors++; $display("FAIL reset_sel_err got %b want 0", sel_err); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    in_sel = 2'd2; in_data = 8'hA5; in_valid = 1'b1; out_ready = '0;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 4'b0100) begin errors++; $display("FAIL single_valid got %b want 0100", out_valid); end
    checks++;
    if (out_data !== 32'h00A5_0000) begin errors++; $display("FAIL single_data got %h want 00a50000", out_data); end
  endtask

  // channel 2 is still held from test_single
  task automatic test_hold();
    @(negedge clk);
    in_sel = 2'd1; in_data = 8'h77; in_valid = 1'b1; out_ready = '0;
    @(negedge clk);
    in_sel = 2'd1; in_data = 8'h99; in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_ready_blocked got %b want 0", in_ready); end
    @(negedge clk);
    in_sel = 2'd3; in_data = 8'h3C; in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_ready_other got %b want 1", in_ready); end
    checks++;
    if (out_data[15:8] !== 8'h77) begin errors++; $display("FAIL hold_stable got %h want 77", out_data[15:8]); end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 4'b1110) begin errors++; $display("FAIL hold_valid got %b want 1110", out_valid); end
    checks++;
    if (out_data !== 32'h3CA5_7700) begin errors++; $display("FAIL hold_data got %h want 3ca57700", out_data); end
    out_ready = 4'b1111;
    @(negedge clk);
    out_ready = '0;
    #1;
    checks++;
    if (out_valid !== 4'b0000) begin errors++; $display("FAIL hold_drain got %b want 0000", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 4'b1111;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      in_sel = 2'd0; in_data = 8'(i); in_valid = (i <= 4);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready beat %0d got %b want 1", i, in_ready); end
      if (i > 1) begin
        checks++;
        if (out_valid[0] !== 1'b1 || out_data[7:0] !== 8'(i - 1)) begin
          errors++; $display("FAIL b2b_deliver beat %0d got v=%b d=%h want v=1 d=%h", i, out_valid[0], out_data[7:0], 8'(i - 1));
        end
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 4'b0000) begin errors++; $display("FAIL b2b_empty got %b want 0000", out_valid); end
    out_ready = '0;
  endtask

  task automatic test_sel_err();
    @(negedge clk);
    in_sel3 = 2'd1; in_data3 = 8'h42; in_valid3 = 1'b1; out_ready3 = '0;
    @(negedge clk);
    in_sel3 = 2'd3; in_data3 = 8'hFF; in_valid3 = 1'b1;
    #1;
    checks++;
    if (in_ready3 !== 1'b1) begin errors++; $display("FAIL selerr_ready got %b want 1", in_ready3); end
    checks++;
    if (sel_err3 !== 1'b0) begin errors++; $display("FAIL selerr_early got %b want 0", sel_err3); end
    @(negedge clk);
    in_valid3 = 1'b0;
    #1;
    checks++;
    if (out_valid3 !== 3'b010 || out_data3 !== 24'h00_4200) begin
      errors++; $display("FAIL selerr_channels got v=%b d=%h want v=010 d=004200", out_valid3, out_data3);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_ready3 = 3'b111;
      #1;
      checks++;
      if (sel_err3 !== 1'b1) begin errors++; $display("FAIL selerr_sticky cycle %0d got %b want 1", i, sel_err3); end
    end
    do_reset();
    #1;
    checks++;
    if (sel_err3 !== 1'b0) begin errors++; $display("FAIL selerr_cleared got %b want 0", sel_err3); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    in_sel = 2'd0; in_data = 8'h11; in_valid = 1'b1; out_ready = '0;
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 4'b0000 || out_data !== 32'h0) begin
      errors++; $display("FAIL async_reset got v=%b d=%h want v=0000 d=0", out_valid, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 4'b1111;
    in_sel = 2'd1; in_data = 8'h5A; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 4'b0010 || out_data[15:8] !== 8'h5A) begin
      errors++; $display("FAIL first_after_reset got v=%b d=%h want v=0010 d=5a", out_valid, out_data[15:8]);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL no_stale_beat cycle %0d got %b want 0", i, out_valid[0]); end
    end
    out_ready = '0;
  endtask

  task automatic test_random();
    logic        exp_ready;
    logic [3:0]  exp_valid;
    logic [31:0] exp_data, mask;
    do_reset();
    for (int k = 0; k < 4; k++) mq[k].delete();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      in_sel = 2'($urandom_range(0, 3));
      in_data = 8'($urandom);
      for (int k = 0; k < 4; k++) out_ready[k] = ($urandom_range(0, 9) < 6);
      #1;
      exp_ready = (mq[in_sel].size() == 0) || out_ready[in_sel];
      exp_valid = '0; exp_data = '0; mask = '0;
      for (int k = 0; k < 4; k++) begin
        if (mq[k].size() != 0) begin
          exp_valid[k] = 1'b1;
          exp_data[k*8 +: 8] = mq[k][0];
          mask[k*8 +: 8] = 8'hFF;
        end
      end
      checks++;
      if (in_ready !== exp_ready) begin errors++; $display("FAIL rand_ready cyc %0d got %b want %b", n, in_ready, exp_ready); end
      checks++;
      if (out_valid !== exp_valid) begin errors++; $display("FAIL rand_valid cyc %0d got %b want %b", n, out_valid, exp_valid); end
      checks++;
      if ((out_data & mask) !== exp_data) begin errors++; $display("FAIL rand_data cyc %0d got %h want %h", n, out_data & mask, exp_data); end
      for (int k = 0; k < 4; k++)
        if (out_ready[k] && mq[k].size() != 0) void'(mq[k].pop_front());
      if (in_valid && exp_ready) mq[in_sel].push_back(in_data);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = '0;
    checks++;
    if (sel_err !== 1'b0) begin errors++; $display("FAIL rand_sel_err got %b want 0", sel_err); end
  endtask

`ifdef DEMUX_CNT_EN
  task automatic test_counter();
    do_reset();
    out_ready = 4'b0010;
    for (int i = 0; i < 65537; i++) begin
      @(negedge clk);
      in_sel = 2'd1; in_data = 8'(i); in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (beat_cnt !== 64'h0000_0000_0001_0000) begin
      errors++; $display("FAIL beat_cnt got %h want 0000000000010000", beat_cnt);
    end
    out_ready = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_hold();
    test_back_to_back();
    test_sel_err();
    test_async_reset();
    test_random();
`ifdef DEMUX_CNT_EN
    test_counter();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
